// File: rtl/matcher_pkg.sv
// matcher_pkg: shared defaults and state encoding for the order matcher.
//   PRICE_W_DEF / QTY_W_DEF : default price and quantity widths
//   state_e                 : crossing FSM states IDLE -> MATCH -> GAP
package matcher_pkg;

   localparam int PRICE_W_DEF = 16;
   localparam int QTY_W_DEF   = 8;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_MATCH_ENC = 2'd1;
   localparam logic [1:0] ST_GAP_ENC   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_MATCH = ST_MATCH_ENC,
      ST_GAP   = ST_GAP_ENC
   } state_e;

endpackage

// File: rtl/order_slot.sv
// order_slot: one resting order (price, remaining qty, occupied flag).
//   clk, reset            : clock, synchronous active-high reset
//   load, load_price/qty  : capture a new order (zero qty is dropped, slot stays empty)
//   dec, dec_qty          : reduce the remaining qty by a fill; slot empties at zero
//   price, qty, live      : registered resting order state
import matcher_pkg::*;

module order_slot #(
   parameter int PRICE_W = PRICE_W_DEF,
   parameter int QTY_W   = QTY_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [PRICE_W-1:0] load_price,
   input  logic [QTY_W-1:0]   load_qty,
   input  logic               dec,
   input  logic [QTY_W-1:0]   dec_qty,
   output logic [PRICE_W-1:0] price,
   output logic [QTY_W-1:0]   qty,
   output logic               live
);

   logic [PRICE_W-1:0] price_r;
   logic [QTY_W-1:0]   qty_r;
   logic               live_r;
   logic [QTY_W-1:0]   rem_s;

   // Fill never exceeds the resting qty, so this cannot underflow.
   assign rem_s = qty_r - dec_qty;

   // Slot state: a fill takes priority; a load only arrives while the slot is empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         price_r <= {PRICE_W{1'b0}};
         qty_r   <= {QTY_W{1'b0}};
         live_r  <= 1'b0;
      end else if (dec) begin
         qty_r   <= rem_s;
         live_r  <= (rem_s != {QTY_W{1'b0}});
      end else if (load) begin
         price_r <= load_price;
         qty_r   <= load_qty;
         live_r  <= (load_qty != {QTY_W{1'b0}});
      end else begin
         price_r <= price_r;
         qty_r   <= qty_r;
         live_r  <= live_r;
      end
   end

   assign price = price_r;
   assign qty   = qty_r;
   assign live  = live_r;

endmodule

// File: rtl/order_matcher.sv
// order_matcher: single-level crossing engine, one resting bid and one resting ask.
//   clk, reset                       : clock, synchronous active-high reset
//   bid_valid/ready/price/qty        : bid order handshake (ready = bid slot empty)
//   ask_valid/ready/price/qty        : ask order handshake (ready = ask slot empty)
//   halt_signal                      : blocks new matches while high (sampled in IDLE)
//   match_siganl                     : one-cycle trade pulse, always followed by a low cycle
//   trade_price, trade_qty           : trade details, held between pulses
//   bid_live, ask_live               : slot occupied flags
import matcher_pkg::*;

module order_matcher #(
   parameter int PRICE_W = PRICE_W_DEF,
   parameter int QTY_W   = QTY_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               bid_valid,
   output logic               bid_ready,
   input  logic [PRICE_W-1:0] bid_price,
   input  logic [QTY_W-1:0]   bid_qty,
   input  logic               ask_valid,
   output logic               ask_ready,
   input  logic [PRICE_W-1:0] ask_price,
   input  logic [QTY_W-1:0]   ask_qty,
   input  logic               halt_signal,
   output logic               match_siganl,
   output logic [PRICE_W-1:0] trade_price,
   output logic [QTY_W-1:0]   trade_qty,
   output logic               bid_live,
   output logic               ask_live
);

   state_e             state_r;
   state_e             state_nxt_s;
   logic               take_s;
   logic               cross_s;
   logic [QTY_W-1:0]   fill_qty_s;
   logic [PRICE_W-1:0] bid_price_s;
   logic [PRICE_W-1:0] ask_price_s;
   logic [QTY_W-1:0]   bid_qty_s;
   logic [QTY_W-1:0]   ask_qty_s;
   logic               bid_live_s;
   logic               ask_live_s;
   logic               match_r;
   logic [PRICE_W-1:0] trade_price_r;
   logic [QTY_W-1:0]   trade_qty_r;

   order_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) u_bid_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (bid_valid & bid_ready),
      .load_price (bid_price),
      .load_qty   (bid_qty),
      .dec        (take_s),
      .dec_qty    (fill_qty_s),
      .price      (bid_price_s),
      .qty        (bid_qty_s),
      .live       (bid_live_s)
   );

   order_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) u_ask_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (ask_valid & ask_ready),
      .load_price (ask_price),
      .load_qty   (ask_qty),
      .dec        (take_s),
      .dec_qty    (fill_qty_s),
      .price      (ask_price_s),
      .qty        (ask_qty_s),
      .live       (ask_live_s)
   );

   // Ready depends only on slot occupancy, never on the offered valid.
   assign bid_ready = ~bid_live_s;
   assign ask_ready = ~ask_live_s;

   // Crossing is judged on the registered book only.
   assign cross_s    = bid_live_s & ask_live_s & (bid_price_s >= ask_price_s) & ~halt_signal;
   assign fill_qty_s = (bid_qty_s < ask_qty_s) ? bid_qty_s : ask_qty_s;

   // Next-state logic; take_s marks the MATCH entry edge where both slots are filled.
   always_comb begin
      state_nxt_s = state_r;
      take_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cross_s) begin
               state_nxt_s = ST_MATCH;
               take_s      = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MATCH: state_nxt_s = ST_GAP;
         ST_GAP:   state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Trade output registers: pulse for the MATCH cycle, details held until the next trade.
   always_ff @(posedge clk) begin
      if (reset) begin
         match_r       <= 1'b0;
         trade_price_r <= {PRICE_W{1'b0}};
         trade_qty_r   <= {QTY_W{1'b0}};
      end else if (take_s) begin
         match_r       <= 1'b1;
         trade_price_r <= ask_price_s;
         trade_qty_r   <= fill_qty_s;
      end else begin
         match_r       <= 1'b0;
         trade_price_r <= trade_price_r;
         trade_qty_r   <= trade_qty_r;
      end
   end

   assign match_siganl = match_r;
   assign trade_price  = trade_price_r;
   assign trade_qty    = trade_qty_r;
   assign bid_live     = bid_live_s;
   assign ask_live     = ask_live_s;

endmodule

// File: tb/tb_order_matcher.sv
// tb_order_matcher: self-checking bench for order_matcher.
// Expected trades are queued when a crossing pair is driven and compared
// against every match_siganl pulse observed on the falling clock edge.
module tb_order_matcher;

   typedef struct packed {
      logic [15:0] price;
      logic [7:0]  qty;
   } trade_t;

   logic        clk;
   logic        reset;
   logic        bid_valid;
   logic        bid_ready;
   logic [15:0] bid_price;
   logic [7:0]  bid_qty;
   logic        ask_valid;
   logic        ask_ready;
   logic [15:0] ask_price;
   logic [7:0]  ask_qty;
   logic        halt_signal;
   logic        match_siganl;
   logic [15:0] trade_price;
   logic [7:0]  trade_qty;
   logic        bid_live;
   logic        ask_live;

   trade_t exp_q[$];
   int     checks = 0;
   int     errors = 0;
   int     pulse_cnt = 0;
   logic   prev_match = 1'b0;

   order_matcher dut (
      .clk          (clk),
      .reset        (reset),
      .bid_valid    (bid_valid),
      .bid_ready    (bid_ready),
      .bid_price    (bid_price),
      .bid_qty      (bid_qty),
      .ask_valid    (ask_valid),
      .ask_ready    (ask_ready),
      .ask_price    (ask_price),
      .ask_qty      (ask_qty),
      .halt_signal  (halt_signal),
      .match_siganl (match_siganl),
      .trade_price  (trade_price),
      .trade_qty    (trade_qty),
      .bid_live     (bid_live),
      .ask_live     (ask_live)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every pulse must match the oldest queued trade.
   always @(negedge clk) begin
      if (match_siganl === 1'b1) begin
         pulse_cnt <= pulse_cnt + 1;
         check_val("pulse_gap", {31'd0, prev_match}, 32'd0);
         check_val("trade_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            trade_t t;
            t = exp_q.pop_front();
            check_val("trade_price", {16'd0, trade_price}, {16'd0, t.price});
            check_val("trade_qty", {24'd0, trade_qty}, {24'd0, t.qty});
         end
      end
      prev_match <= match_siganl;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_trade(input logic [15:0] p, input logic [7:0] q);
      trade_t t;
      t.price = p;
      t.qty   = q;
      exp_q.push_back(t);
   endtask

   task automatic put_bid(input logic [15:0] p, input logic [7:0] q);
      check_val("bid_ready_pre", {31'd0, bid_ready}, 32'd1);
      bid_valid = 1'b1; bid_price = p; bid_qty = q;
      @(negedge clk);
      bid_valid = 1'b0;
   endtask

   task automatic put_ask(input logic [15:0] p, input logic [7:0] q);
      check_val("ask_ready_pre", {31'd0, ask_ready}, 32'd1);
      ask_valid = 1'b1; ask_price = p; ask_qty = q;
      @(negedge clk);
      ask_valid = 1'b0;
   endtask

   task automatic put_both(input logic [15:0] bp, input logic [7:0] bq,
                           input logic [15:0] ap, input logic [7:0] aq);
      bid_valid = 1'b1; bid_price = bp; bid_qty = bq;
      ask_valid = 1'b1; ask_price = ap; ask_qty = aq;
      @(negedge clk);
      bid_valid = 1'b0;
      ask_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      logic [15:0] ap, bp;
      logic [7:0]  aq, bq, mq;

      reset = 1'b1; halt_signal = 1'b0;
      bid_valid = 1'b0; bid_price = 16'd0; bid_qty = 8'd0;
      ask_valid = 1'b0; ask_price = 16'd0; ask_qty = 8'd0;
      tick(2);
      // reset state
      check_val("rst_match", {31'd0, match_siganl}, 32'd0);
      check_val("rst_tprice", {16'd0, trade_price}, 32'd0);
      check_val("rst_tqty", {24'd0, trade_qty}, 32'd0);
      check_val("rst_live", {30'd0, bid_live, ask_live}, 32'd0);
      check_val("rst_ready", {30'd0, bid_ready, ask_ready}, 32'd3);
      reset = 1'b0;
      tick(1);

      // reset during the MATCH cycle aborts the trade and clears the residual
      put_ask(16'd100, 8'd5);
      push_trade(16'd100, 8'd5);
      put_bid(16'd101, 8'd9);
      tick(1);
      check_val("mid_match_pulse", {31'd0, match_siganl}, 32'd1);
      do_reset();
      check_val("mid_rst_match", {31'd0, match_siganl}, 32'd0);
      check_val("mid_rst_live", {30'd0, bid_live, ask_live}, 32'd0);
      check_val("mid_rst_tqty", {24'd0, trade_qty}, 32'd0);

      // equal-qty full fill with latency check
      put_ask(16'd100, 8'd5);
      push_trade(16'd100, 8'd5);
      put_bid(16'd101, 8'd5);
      check_val("lat_early", {31'd0, match_siganl}, 32'd0);
      tick(1);
      check_val("full_pulse", {31'd0, match_siganl}, 32'd1);
      check_val("full_ready", {30'd0, bid_ready, ask_ready}, 32'd3);
      tick(1);
      check_val("full_gap", {31'd0, match_siganl}, 32'd0);
      check_val("full_hold_price", {16'd0, trade_price}, 32'd100);
      check_val("full_hold_qty", {24'd0, trade_qty}, 32'd5);
      tick(1);

      // partial fill, residual re-matches with a new ask; pulses 3 cycles apart
      put_ask(16'd100, 8'd3);
      push_trade(16'd100, 8'd3);
      put_bid(16'd100, 8'd10);
      tick(1);
      check_val("part_pulse1", {31'd0, match_siganl}, 32'd1);
      check_val("part_live", {30'd0, bid_live, ask_live}, 32'd2);
      push_trade(16'd99, 8'd7);
      put_ask(16'd99, 8'd7);
      check_val("part_gap", {31'd0, match_siganl}, 32'd0);
      tick(1);
      check_val("part_idle", {31'd0, match_siganl}, 32'd0);
      tick(1);
      check_val("part_pulse2", {31'd0, match_siganl}, 32'd1);
      tick(1);
      check_val("part_empty", {30'd0, bid_live, ask_live}, 32'd0);
      tick(1);

      // non-crossing book; held bid_valid must be ignored
      put_bid(16'd99, 8'd4);
      put_ask(16'd100, 8'd4);
      p0 = pulse_cnt;
      bid_valid = 1'b1; bid_price = 16'd200; bid_qty = 8'd4;
      tick(20);
      bid_valid = 1'b0;
      check_val("nocross_pulses", pulse_cnt - p0, 32'd0);
      check_val("nocross_live", {30'd0, bid_live, ask_live}, 32'd3);
      check_val("nocross_ready", {30'd0, bid_ready, ask_ready}, 32'd0);
      do_reset();

      // halt blocks a crossing pair, release lets it trade
      halt_signal = 1'b1;
      put_ask(16'd100, 8'd2);
      put_bid(16'd150, 8'd2);
      p0 = pulse_cnt;
      tick(10);
      check_val("halt_pulses", pulse_cnt - p0, 32'd0);
      check_val("halt_live", {30'd0, bid_live, ask_live}, 32'd3);
      push_trade(16'd100, 8'd2);
      halt_signal = 1'b0;
      tick(1);
      check_val("unhalt_pulse", {31'd0, match_siganl}, 32'd1);
      tick(2);

      // halt raised during MATCH: that trade completes, no further trades
      put_ask(16'd100, 8'd2);
      push_trade(16'd100, 8'd2);
      put_bid(16'd150, 8'd6);
      tick(1);
      check_val("halt_mid_pulse", {31'd0, match_siganl}, 32'd1);
      halt_signal = 1'b1;
      put_ask(16'd120, 8'd4);
      check_val("halt_mid_gap", {31'd0, match_siganl}, 32'd0);
      p0 = pulse_cnt;
      tick(10);
      check_val("halt_mid_pulses", pulse_cnt - p0, 32'd0);
      check_val("halt_mid_live", {30'd0, bid_live, ask_live}, 32'd3);
      push_trade(16'd120, 8'd4);
      halt_signal = 1'b0;
      tick(1);
      check_val("resume_pulse", {31'd0, match_siganl}, 32'd1);
      tick(2);

      // zero-qty bid is accepted and dropped
      put_bid(16'd120, 8'd0);
      check_val("zero_live", {31'd0, bid_live}, 32'd0);
      check_val("zero_ready", {31'd0, bid_ready}, 32'd1);

      // simultaneous accept of both sides
      push_trade(16'd50, 8'd1);
      put_both(16'd60, 8'd1, 16'd50, 8'd1);
      check_val("sim_live", {30'd0, bid_live, ask_live}, 32'd3);
      tick(1);
      check_val("sim_pulse", {31'd0, match_siganl}, 32'd1);
      tick(2);

      // random crossing pairs
      for (int i = 0; i < 6; i++) begin
         ap = 16'($urandom_range(1000, 100));
         bp = ap + 16'($urandom_range(50, 0));
         aq = 8'($urandom_range(255, 1));
         bq = 8'($urandom_range(255, 1));
         mq = (bq < aq) ? bq : aq;
         push_trade(ap, mq);
         put_both(bp, bq, ap, aq);
         tick(1);
         check_val("rnd_pulse", {31'd0, match_siganl}, 32'd1);
         check_val("rnd_bid_live", {31'd0, bid_live}, {31'd0, bq > aq});
         check_val("rnd_ask_live", {31'd0, ask_live}, {31'd0, aq > bq});
         do_reset();
      end

      tick(3);
      check_val("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
